// File: rtl/mips_control_sequencer_if.sv
// Handshake/bus bundle between the instruction register, memory and the control sequencer.
// The sequencer takes the slave view; the datapath/testbench side takes the master view.
interface mips_control_sequencer_if;
  logic [5:0] opcode;
  logic [5:0] func_code;
  logic [4:0] rt_code;
  logic       waitrequest;
  logic       jump_target_zero;

  logic [2:0] state;
  logic       active;
  logic       mem_read;
  logic       mem_write;
  logic       pc_write;
  logic       ir_write;
  logic       hilo_write;
  logic       stall;

  modport slave (
    input  opcode, func_code, rt_code, waitrequest, jump_target_zero,
    output state, active, mem_read, mem_write, pc_write, ir_write, hilo_write, stall
  );

  modport master (
    output opcode, func_code, rt_code, waitrequest, jump_target_zero,
    input  state, active, mem_read, mem_write, pc_write, ir_write, hilo_write, stall
  );
endinterface

// File: rtl/mips_control_sequencer.sv
// Multicycle MIPS state register with time-dependent strobes: waitrequest stretching,
// a parametrised mul/div stall, and a halt on a register jump to address 0.
module mips_control_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  mips_control_sequencer_if.slave   bus_if
);

  typedef enum logic [2:0] {
    S_FETCH        = 3'd0,
    S_DECODE       = 3'd1,
    S_EXECUTE      = 3'd2,
    S_MEMORY       = 3'd3,
    S_WRITE_BACK   = 3'd4,
    S_MULDIV_STALL = 3'd5,
    S_HALTED       = 3'd6,
    S_INVALID      = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;

  logic w_is_load;
  logic w_is_store;
  logic w_is_muldiv;
  logic w_is_div;
  logic w_is_jreg;
  logic w_is_mem;
  logic w_cnt_zero;

  logic w_mem_read;
  logic w_mem_write;
  logic w_pc_write;
  logic w_ir_write;
  logic w_hilo_write;
  logic w_stall;

  // rt_code selects REGIMM variants, none of which need sequencing beyond OTHER
  logic w_unused_rt;
  assign w_unused_rt = ^bus_if.rt_code;

  always_comb begin
    w_is_load   = (bus_if.opcode >= 6'h20) && (bus_if.opcode <= 6'h26);
    w_is_store  = (bus_if.opcode == 6'h28) || (bus_if.opcode == 6'h29) ||
                  (bus_if.opcode == 6'h2B);
    w_is_muldiv = (bus_if.opcode == 6'h00) &&
                  (bus_if.func_code >= 6'h18) && (bus_if.func_code <= 6'h1B);
    w_is_div    = bus_if.func_code[1];
    w_is_jreg   = (bus_if.opcode == 6'h00) &&
                  ((bus_if.func_code == 6'h08) || (bus_if.func_code == 6'h09));
    w_is_mem    = w_is_load || w_is_store;
    w_cnt_zero  = (r_cnt == '0);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_hilo_write = 1'b0;
    w_stall      = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_pc_write = !bus_if.waitrequest;
        w_stall    = bus_if.waitrequest;
        if (!bus_if.waitrequest) w_next_state = S_DECODE;
      end

      S_DECODE: begin
        w_ir_write   = 1'b1;
        w_next_state = S_EXECUTE;
      end

      S_EXECUTE: begin
        if (w_is_muldiv) begin
          w_next_state = S_MULDIV_STALL;
          w_next_cnt   = w_is_div ? DIV_LOAD : MUL_LOAD;
        end else begin
          w_next_state = S_MEMORY;
        end
      end

      // The final (counter == 0) cycle of the stall is the HI/LO capture cycle
      S_MULDIV_STALL: begin
        if (!w_cnt_zero) begin
          w_stall    = 1'b1;
          w_next_cnt = r_cnt - 1'b1;
        end else begin
          w_hilo_write = 1'b1;
          w_next_state = S_MEMORY;
        end
      end

      S_MEMORY: begin
        w_mem_read  = w_is_load;
        w_mem_write = w_is_store;
        if (w_is_mem && bus_if.waitrequest) begin
          w_stall = 1'b1;
        end else if (w_is_load) begin
          w_next_state = S_WRITE_BACK;
        end else if (w_is_jreg && bus_if.jump_target_zero) begin
          w_next_state = S_HALTED;
        end else begin
          w_next_state = S_FETCH;
        end
      end

      S_WRITE_BACK: w_next_state = S_FETCH;

      S_HALTED: w_next_state = S_HALTED;

      default: w_next_state = S_FETCH;
    endcase
  end

  assign bus_if.state      = r_state;
  assign bus_if.active     = (r_state != S_HALTED);
  assign bus_if.mem_read   = w_mem_read;
  assign bus_if.mem_write  = w_mem_write;
  assign bus_if.pc_write   = w_pc_write;
  assign bus_if.ir_write   = w_ir_write;
  assign bus_if.hilo_write = w_hilo_write;
  assign bus_if.stall      = w_stall;

endmodule

// File: tb/tb_mips_control_sequencer.sv
// Directed bench for mips_control_sequencer: a per-cycle vector table plus
// hand-written sequences for mul/div stalls, halt, and asynchronous reset aborts.
module tb_mips_control_sequencer;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  mips_control_sequencer_if bus_a ();
  mips_control_sequencer_if bus_b ();

  mips_control_sequencer #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
    .i_clk   (clk),
    .i_reset (rst_a),
    .bus_if  (bus_a)
  );

  mips_control_sequencer #(.MUL_CYCLES(1), .DIV_CYCLES(3), .CNT_W(6)) dut_b (
    .i_clk   (clk),
    .i_reset (rst_b),
    .bus_if  (bus_b)
  );

  // flags order: {mem_read, mem_write, pc_write, ir_write, hilo_write, stall, active}
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       wr;
    logic       jtz;
    logic [2:0] st;
    logic [6:0] fl;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(input logic [5:0] op, input logic [5:0] fn, input logic wr,
                              input logic jtz, input logic [2:0] st, input logic [6:0] fl);
    vec_t v;
    v.op = op; v.fn = fn; v.wr = wr; v.jtz = jtz; v.st = st; v.fl = fl;
    vecs.push_back(v);
  endfunction

  function automatic logic [6:0] flags_a();
    return {bus_a.mem_read, bus_a.mem_write, bus_a.pc_write, bus_a.ir_write,
            bus_a.hilo_write, bus_a.stall, bus_a.active};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_a(input logic [5:0] op, input logic [5:0] fn, input logic wr,
                         input logic jtz);
    bus_a.opcode = op; bus_a.func_code = fn; bus_a.waitrequest = wr;
    bus_a.jump_target_zero = jtz;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n5;
    int nst;
    int nh;
    int hilo_last;
    int saw_mem;
    int done;

    bus_a.rt_code = '0; bus_b.rt_code = '0;
    drive_a(6'h09, 6'h00, 1'b0, 1'b0);
    bus_b.opcode = 6'h00; bus_b.func_code = 6'h18;
    bus_b.waitrequest = 1'b0; bus_b.jump_target_zero = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;

    #2;
    chk("reset state", 32'(bus_a.state), 0);
    chk("reset flags", 32'(flags_a()), 32'b1010001);
    bus_a.waitrequest = 1'b1;
    #1;
    chk("reset pc_write with wait", 32'(bus_a.pc_write), 0);
    chk("reset stall with wait", 32'(bus_a.stall), 1);
    bus_a.waitrequest = 1'b0;
    chk("reset counter", 32'(dut.r_cnt), 0);

    // ADDIU, no wait states
    add(6'h09, 0, 0, 0, 0, 7'b1010001);
    add(6'h09, 0, 0, 0, 1, 7'b0001001);
    add(6'h09, 0, 0, 0, 2, 7'b0000001);
    add(6'h09, 0, 0, 0, 3, 7'b0000001);
    // LW: 3 fetch waits, 2 memory waits, wait ignored in DECODE and WRITE_BACK
    add(6'h23, 0, 1, 0, 0, 7'b1000011);
    add(6'h23, 0, 1, 0, 0, 7'b1000011);
    add(6'h23, 0, 1, 0, 0, 7'b1000011);
    add(6'h23, 0, 0, 0, 0, 7'b1010001);
    add(6'h23, 0, 1, 0, 1, 7'b0001001);
    add(6'h23, 0, 0, 0, 2, 7'b0000001);
    add(6'h23, 0, 1, 0, 3, 7'b1000011);
    add(6'h23, 0, 1, 0, 3, 7'b1000011);
    add(6'h23, 0, 0, 0, 3, 7'b1000001);
    add(6'h23, 0, 1, 0, 4, 7'b0000001);
    // SW with one memory wait
    add(6'h2B, 0, 0, 0, 0, 7'b1010001);
    add(6'h2B, 0, 0, 0, 1, 7'b0001001);
    add(6'h2B, 0, 0, 0, 2, 7'b0000001);
    add(6'h2B, 0, 1, 0, 3, 7'b0100011);
    add(6'h2B, 0, 0, 0, 3, 7'b0100001);
    // ADDIU: waitrequest ignored in EXECUTE and MEMORY_ACCESS
    add(6'h09, 0, 0, 0, 0, 7'b1010001);
    add(6'h09, 0, 0, 0, 1, 7'b0001001);
    add(6'h09, 0, 1, 0, 2, 7'b0000001);
    add(6'h09, 0, 1, 0, 3, 7'b0000001);
    // MULT, MUL_CYCLES=4, wait ignored during stall
    add(6'h00, 6'h18, 0, 0, 0, 7'b1010001);
    add(6'h00, 6'h18, 0, 0, 1, 7'b0001001);
    add(6'h00, 6'h18, 0, 0, 2, 7'b0000001);
    add(6'h00, 6'h18, 1, 0, 5, 7'b0000011);
    add(6'h00, 6'h18, 0, 0, 5, 7'b0000011);
    add(6'h00, 6'h18, 1, 0, 5, 7'b0000011);
    add(6'h00, 6'h18, 0, 0, 5, 7'b0000101);
    add(6'h00, 6'h18, 1, 0, 3, 7'b0000001);
    // JR with nonzero target; jtz outside MEMORY_ACCESS is ignored
    add(6'h00, 6'h08, 0, 0, 0, 7'b1010001);
    add(6'h00, 6'h08, 0, 1, 1, 7'b0001001);
    add(6'h00, 6'h08, 0, 1, 2, 7'b0000001);
    add(6'h00, 6'h08, 0, 0, 3, 7'b0000001);
    // SWL is OTHER: no strobes, no stall in MEMORY_ACCESS
    add(6'h2A, 0, 0, 0, 0, 7'b1010001);
    add(6'h2A, 0, 0, 0, 1, 7'b0001001);
    add(6'h2A, 0, 0, 0, 2, 7'b0000001);
    add(6'h2A, 0, 1, 0, 3, 7'b0000001);

    @(negedge clk);
    rst_a = 1'b0;
    foreach (vecs[i]) begin
      drive_a(vecs[i].op, vecs[i].fn, vecs[i].wr, vecs[i].jtz);
      #1;
      chk($sformatf("vec%0d state", i), 32'(bus_a.state), 32'(vecs[i].st));
      chk($sformatf("vec%0d flags", i), 32'(flags_a()), 32'(vecs[i].fl));
      tick();
    end
    chk("after table state", 32'(bus_a.state), 0);

    // DIVU with DIV_CYCLES=32; waitrequest asserted while stalled must be ignored
    n5 = 0; nst = 0; nh = 0; hilo_last = 0; saw_mem = 0; done = 0;
    drive_a(6'h00, 6'h1B, 1'b0, 1'b0);
    for (int c = 0; c < 60 && done == 0; c++) begin
      bus_a.waitrequest = (bus_a.state == 3'd5);
      #1;
      if (bus_a.state == 3'd5) begin
        n5++;
        if (bus_a.stall) nst++;
        hilo_last = bus_a.hilo_write ? 1 : 0;
      end
      if (bus_a.hilo_write) nh++;
      if (bus_a.state == 3'd3) begin
        saw_mem = 1;
        done = 1;
      end
      tick();
    end
    chk("divu stall cycles", 32'(n5), 32);
    chk("divu stall asserted", 32'(nst), 31);
    chk("divu hilo pulses", 32'(nh), 1);
    chk("divu hilo on last stall cycle", 32'(hilo_last), 1);
    chk("divu reaches memory", 32'(saw_mem), 1);
    chk("divu back to fetch", 32'(bus_a.state), 0);

    // JR to address 0 halts the core
    drive_a(6'h00, 6'h08, 1'b0, 1'b1);
    tick(); tick(); tick();
    chk("jr mem state", 32'(bus_a.state), 3);
    tick();
    chk("halted state", 32'(bus_a.state), 6);
    chk("halted flags", 32'(flags_a()), 0);
    for (int c = 0; c < 20; c++) begin
      drive_a(6'h23, 6'h00, c[0], c[1]);
      #1;
      chk($sformatf("halt cyc%0d state", c), 32'(bus_a.state), 6);
      chk($sformatf("halt cyc%0d flags", c), 32'(flags_a()), 0);
      tick();
    end
    drive_a(6'h09, 6'h00, 1'b0, 1'b0);
    rst_a = 1'b1;
    #1;
    chk("reset from halt state", 32'(bus_a.state), 0);
    chk("reset from halt flags", 32'(flags_a()), 32'b1010001);

    // SW aborted by reset in its second memory wait cycle
    @(negedge clk);
    rst_a = 1'b0;
    drive_a(6'h2B, 6'h00, 1'b0, 1'b0);
    tick(); tick();
    bus_a.waitrequest = 1'b1;
    tick(); tick();
    chk("sw wait2 state", 32'(bus_a.state), 3);
    chk("sw wait2 mem_write", 32'(bus_a.mem_write), 1);
    rst_a = 1'b1;
    #1;
    chk("sw abort state", 32'(bus_a.state), 0);
    chk("sw abort mem_write", 32'(bus_a.mem_write), 0);
    chk("sw abort counter", 32'(dut.r_cnt), 0);

    // DIVU aborted mid-stall
    @(negedge clk);
    rst_a = 1'b0;
    drive_a(6'h00, 6'h1A, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) tick();
    chk("div mid-stall state", 32'(bus_a.state), 5);
    chk("div mid-stall counter", 32'(dut.r_cnt), 26);
    rst_a = 1'b1;
    #1;
    chk("div abort state", 32'(bus_a.state), 0);
    chk("div abort counter", 32'(dut.r_cnt), 0);
    chk("div abort hilo", 32'(bus_a.hilo_write), 0);
    tick();
    chk("div abort held", 32'(bus_a.state), 0);

    // Instance B: MUL_CYCLES=1 and DIV_CYCLES=3
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    chk("b fetch", 32'(bus_b.state), 0);
    tick(); tick(); tick();
    chk("b mult state", 32'(bus_b.state), 5);
    chk("b mult hilo", 32'(bus_b.hilo_write), 1);
    chk("b mult stall", 32'(bus_b.stall), 0);
    tick();
    chk("b mult mem", 32'(bus_b.state), 3);
    chk("b mult hilo off", 32'(bus_b.hilo_write), 0);
    tick();
    bus_b.func_code = 6'h1B;
    tick(); tick(); tick();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("b divu cyc%0d state", c), 32'(bus_b.state), 5);
      chk($sformatf("b divu cyc%0d hilo", c), 32'(bus_b.hilo_write), (c == 2) ? 1 : 0);
      chk($sformatf("b divu cyc%0d stall", c), 32'(bus_b.stall), (c == 2) ? 0 : 1);
      tick();
    end
    chk("b divu mem", 32'(bus_b.state), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
